// File: rtl/lock_pkg.sv
// Shared encodings for the lock access protocol: controller states, requester FSM states
// and requester error codes.
package lock_pkg;

  localparam logic [2:0] LOCK_INACTIVE = 3'b000;
  localparam logic [2:0] LOCK_ACTIVE   = 3'b001;
  localparam logic [2:0] LOCK_REQUEST  = 3'b101;
  localparam logic [2:0] LOCK_TRAP     = 3'b111;
  localparam logic [2:0] LOCK_SAVE     = 3'b110;

  localparam logic [1:0] ERR_OK      = 2'b00;
  localparam logic [1:0] ERR_TRAP    = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;
  localparam logic [1:0] ERR_LINK    = 2'b11;

  typedef enum logic [2:0] {
    StIdle,
    StRaise,
    StSendPass,
    StWaitGrant,
    StSendData,
    StWaitSave,
    StHold,
    StRelease
  } req_state_e;

  // States in which the requester is waiting on the controller.
  function automatic logic is_wait_state(req_state_e s);
    return s inside {StRaise, StWaitGrant, StWaitSave, StRelease};
  endfunction

endpackage

// File: rtl/lock_requester_if.sv
// Link between the lock requester (master) and the lock controller (slave).
interface lock_requester_if;
  logic       rqst;
  logic       confirm;
  logic [3:0] pass_data;
  logic [2:0] lock_state;

  modport master (output rqst, output confirm, output pass_data, input lock_state);
  modport slave  (input rqst, input confirm, input pass_data, output lock_state);
endinterface

// File: rtl/lock_req_timer.sv
// Loadable up/down counter shared by the hold and wait-timeout functions of the requester.
module lock_req_timer #(
  parameter int unsigned Width = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [Width-1:0] load_val,
  input  logic             dec,
  input  logic             inc,
  output logic [Width-1:0] count
);

  logic [Width-1:0] count_q, count_d;

  always_comb begin
    count_d = count_q;
    if (load) begin
      count_d = load_val;
    end else if (dec) begin
      count_d = count_q - Width'(1);
    end else if (inc) begin
      count_d = count_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/lock_requester.sv
// Initiator side of the lock access protocol: one start pulse runs open, password, save, release.
// Optional wait-state timeout enabled by defining LOCK_REQ_TIMEOUT_EN.
module lock_requester
  import lock_pkg::*;
#(
  parameter int unsigned HOLD_CYCLES    = 2,
  parameter int unsigned TIMEOUT_CYCLES = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    start,
  input  logic [3:0]              pass_in,
  input  logic [3:0]              data_in,
  lock_requester_if.master        lk,
  output logic                    busy,
  output logic                    done,
  output logic [1:0]              err_code
);

`ifdef LOCK_REQ_TIMEOUT_EN
  localparam bit TimeoutEn = 1'b1;
`else
  localparam bit TimeoutEn = 1'b0;
`endif

  localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);
  localparam logic [7:0] HoldLoad    = 8'(HOLD_CYCLES - 1);

  req_state_e state_q, state_d;
  logic       rqst_q, rqst_d;
  logic       confirm_q, confirm_d;
  logic [3:0] pdata_q, pdata_d;
  logic [3:0] pass_q, pass_d;
  logic [3:0] data_q, data_d;
  logic       done_q, done_d;
  logic [1:0] err_q, err_d;
  logic       busy_q;

  logic       tmr_load, tmr_dec, tmr_inc;
  logic [7:0] tmr_val, tmr_cnt;
  logic       link_lost, timeout;

  lock_req_timer #(
    .Width (8)
  ) u_timer (
    .clk      (clk),
    .rst      (rst),
    .load     (tmr_load),
    .load_val (tmr_val),
    .dec      (tmr_dec),
    .inc      (tmr_inc),
    .count    (tmr_cnt)
  );

  assign link_lost = (lk.lock_state == LOCK_INACTIVE) &&
                     (state_q inside {StWaitGrant, StWaitSave, StHold});
  assign tmr_inc   = TimeoutEn && is_wait_state(state_q);
  // A normal release completing on the limit cycle is not reported as a timeout.
  assign timeout   = TimeoutEn && is_wait_state(state_q) && (tmr_cnt == TimeoutLast) &&
                     !((state_q == StRelease) && (lk.lock_state == LOCK_INACTIVE));

  always_comb begin
    state_d   = state_q;
    rqst_d    = rqst_q;
    confirm_d = 1'b0;
    pdata_d   = pdata_q;
    pass_d    = pass_q;
    data_d    = data_q;
    done_d    = 1'b0;
    err_d     = err_q;
    tmr_load  = 1'b0;
    tmr_val   = '0;
    tmr_dec   = 1'b0;

    if (link_lost) begin
      rqst_d   = 1'b0;
      err_d    = ERR_LINK;
      state_d  = StRelease;
      tmr_load = 1'b1;
    end else if (timeout) begin
      rqst_d = 1'b0;
      err_d  = ERR_TIMEOUT;
      if (state_q == StRelease) begin
        done_d  = 1'b1;
        pdata_d = '0;
        state_d = StIdle;
      end else begin
        state_d  = StRelease;
        tmr_load = 1'b1;
      end
    end else begin
      unique case (state_q)
        StIdle: begin
          // Never raise rqst unless the controller is idle.
          if (start && (lk.lock_state == LOCK_INACTIVE)) begin
            pass_d   = pass_in;
            data_d   = data_in;
            err_d    = ERR_OK;
            rqst_d   = 1'b1;
            state_d  = StRaise;
            tmr_load = 1'b1;
          end
        end
        StRaise: begin
          if (lk.lock_state == LOCK_ACTIVE) begin
            pdata_d   = pass_q;
            confirm_d = 1'b1;
            state_d   = StSendPass;
          end
        end
        StSendPass: begin
          state_d  = StWaitGrant;
          tmr_load = 1'b1;
        end
        StWaitGrant: begin
          if (lk.lock_state == LOCK_REQUEST) begin
            pdata_d   = data_q;
            confirm_d = 1'b1;
            state_d   = StSendData;
          end else if (lk.lock_state == LOCK_TRAP) begin
            rqst_d   = 1'b0;
            err_d    = ERR_TRAP;
            state_d  = StRelease;
            tmr_load = 1'b1;
          end
        end
        StSendData: begin
          state_d  = StWaitSave;
          tmr_load = 1'b1;
        end
        StWaitSave: begin
          if (lk.lock_state == LOCK_SAVE) begin
            tmr_load = 1'b1;
            tmr_val  = HoldLoad;
            state_d  = StHold;
          end
        end
        StHold: begin
          pdata_d = data_q;
          if (tmr_cnt == 8'd0) begin
            rqst_d   = 1'b0;
            state_d  = StRelease;
            tmr_load = 1'b1;
          end else begin
            tmr_dec = 1'b1;
          end
        end
        StRelease: begin
          if (lk.lock_state == LOCK_INACTIVE) begin
            done_d  = 1'b1;
            pdata_d = '0;
            state_d = StIdle;
          end
        end
        default: state_d = StIdle;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= StIdle;
      rqst_q    <= 1'b0;
      confirm_q <= 1'b0;
      pdata_q   <= '0;
      pass_q    <= '0;
      data_q    <= '0;
      done_q    <= 1'b0;
      err_q     <= ERR_OK;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      rqst_q    <= rqst_d;
      confirm_q <= confirm_d;
      pdata_q   <= pdata_d;
      pass_q    <= pass_d;
      data_q    <= data_d;
      done_q    <= done_d;
      err_q     <= err_d;
      busy_q    <= (state_d != StIdle);
    end
  end

  assign lk.rqst      = rqst_q;
  assign lk.confirm   = confirm_q;
  assign lk.pass_data = pdata_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign err_code     = err_q;

endmodule

// File: tb/tb_lock_requester.sv
// Randomized scoreboard bench for lock_requester with a behavioural lock controller model.
module tb_lock_requester;

  localparam int HOLD = 2;
  localparam int TO   = 15;
  localparam logic [3:0] PW = 4'b1111;

  localparam int KNormal = 0;
  localparam int KLink   = 1;
  localparam int KTime   = 2;

  logic       clk, rst, start, busy, done;
  logic [3:0] pass_in, data_in;
  logic [1:0] err_code;

  lock_requester_if lk ();

  lock_requester #(
    .HOLD_CYCLES    (HOLD),
    .TIMEOUT_CYCLES (TO)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .start    (start),
    .pass_in  (pass_in),
    .data_in  (data_in),
    .lk       (lk),
    .busy     (busy),
    .done     (done),
    .err_code (err_code)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Controller model: registered, reacts one edge after its inputs.
  logic [2:0] ctrl_state = 3'b000;
  logic [3:0] ctrl_dout  = 4'h0;
  logic       ctrl_enl   = 1'b0;
  logic       ctrl_enr   = 1'b0;
  logic       ctrl_rst   = 1'b0;
  logic       ctrl_stuck = 1'b0;

  always @(posedge clk) begin
    if (ctrl_rst || !lk.rqst) begin
      ctrl_state <= 3'b000;
    end else begin
      case (ctrl_state)
        3'b000: begin
          ctrl_state <= ctrl_stuck ? 3'b000 : 3'b001;
          ctrl_dout  <= 4'h0;
          ctrl_enl   <= 1'b0;
          ctrl_enr   <= 1'b0;
        end
        3'b001: if (lk.confirm) begin
          if (lk.pass_data == PW) begin
            ctrl_state <= 3'b101;
          end else begin
            ctrl_state <= 3'b111;
            ctrl_enr   <= 1'b1;
          end
        end
        3'b101: if (lk.confirm) begin
          ctrl_state <= 3'b110;
          ctrl_dout  <= lk.pass_data;
          ctrl_enl   <= 1'b1;
        end
        default: ;
      endcase
    end
  end
  assign lk.lock_state = ctrl_state;

  typedef struct {
    int         start_cyc;
    logic [1:0] err;
    int         lat;
    int         nconf;
    bit         dchk;
    logic [3:0] dout;
    bit         enl;
    bit         enr;
  } exp_t;

  exp_t q[$];
  int n_chk  = 0;
  int n_pass = 0;

  task automatic check(input string name, input int act, input int exp);
    n_chk++;
    if (act == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
  endtask

  // Reference: outcome of a transaction from the protocol rules alone.
  function automatic exp_t model(input int kind, input logic [3:0] pass, input logic [3:0] data,
                                 input int s);
    exp_t e;
    bit ok = (pass == PW);
    e.start_cyc = s;
    e.dout      = data;
    if (kind == KTime) begin
      e.err = 2'b10; e.lat = TO + 1; e.nconf = 0; e.dchk = 0; e.enl = 0; e.enr = 0;
    end else if (kind == KLink) begin
      e.err = 2'b11; e.lat = 9; e.nconf = 2; e.dchk = 1; e.enl = 1; e.enr = 0;
    end else if (ok) begin
      e.err = 2'b00; e.lat = 8 + HOLD; e.nconf = 2; e.dchk = 1; e.enl = 1; e.enr = 0;
    end else begin
      e.err = 2'b01; e.lat = 6; e.nconf = 1; e.dchk = 0; e.enl = 0; e.enr = 1;
    end
    return e;
  endfunction

  // Monitor: checks confirm pacing and pops one expectation per done pulse.
  initial begin
    int   conf_idx = 0;
    logic prev_conf = 1'b0;
    exp_t e;
    forever begin
      @(negedge clk);
      if (rst) begin
        conf_idx  = 0;
        prev_conf = 1'b0;
      end else begin
        if (lk.confirm) begin
          check("confirm_back_to_back", int'(prev_conf), 0);
          if (q.size() > 0) begin
            conf_idx++;
            check("confirm_latency", cyc - q[0].start_cyc, 2 * conf_idx);
          end
        end
        prev_conf = lk.confirm;
        if (done) begin
          if (q.size() == 0) begin
            check("done_without_start", int'(done), 0);
          end else begin
            e = q.pop_front();
            check("err_code", int'(err_code), int'(e.err));
            check("done_latency", cyc - e.start_cyc, e.lat);
            check("confirm_count", conf_idx, e.nconf);
            check("rqst_at_done", int'(lk.rqst), 0);
            check("busy_at_done", int'(busy), 0);
            if (e.dchk) check("ctrl_dout", int'(ctrl_dout), int'(e.dout));
            check("ctrl_en_left", int'(ctrl_enl), int'(e.enl));
            check("ctrl_en_right", int'(ctrl_enr), int'(e.enr));
          end
          conf_idx = 0;
        end
      end
    end
  end

  task automatic check_zero(input string tag);
    check({tag, "_rqst"}, int'(lk.rqst), 0);
    check({tag, "_confirm"}, int'(lk.confirm), 0);
    check({tag, "_pass_data"}, int'(lk.pass_data), 0);
    check({tag, "_busy"}, int'(busy), 0);
    check({tag, "_done"}, int'(done), 0);
    check({tag, "_err_code"}, int'(err_code), 0);
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while ((busy || ctrl_state != 3'b000) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check("idle_before_start", int'(busy), 0);
  endtask

  task automatic drain(input int bound);
    int n = 0;
    while (q.size() != 0 && n < bound) begin
      @(posedge clk);
      n++;
    end
    check("pending_expectations", q.size(), 0);
    q.delete();
  endtask

  task automatic issue_start(input int kind, input logic [3:0] pass, input logic [3:0] data);
    pass_in = pass;
    data_in = data;
    start   = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    q.push_back(model(kind, pass, data, cyc));
    check("busy_after_start", int'(busy), 1);
    check("rqst_after_start", int'(lk.rqst), 1);
    pass_in = 4'($urandom);
    data_in = 4'($urandom);
  endtask

  task automatic do_txn(input int kind, input logic [3:0] pass, input logic [3:0] data,
                        input bit ign);
    wait_idle();
    issue_start(kind, pass, data);
    if (kind == KLink) begin
      repeat (6) @(posedge clk);
      #1 ctrl_rst = 1'b1;
      repeat (2) @(posedge clk);
      #1 ctrl_rst = 1'b0;
    end else if (ign) begin
      repeat (2) @(posedge clk);
      #1 start = 1'b1;
      @(posedge clk);
      #1 start = 1'b0;
    end
    drain(40);
  endtask

  initial begin
    #400000;
    $display("FAIL global_time_limit: got cycle %0d expected finish", cyc);
    $fatal(1);
  end

  initial begin
    rst = 1'b1; start = 1'b0; pass_in = '0; data_in = '0;
    repeat (3) @(posedge clk);
    #1 check_zero("reset");
    rst = 1'b0;

    do_txn(KNormal, 4'b1111, 4'b0101, 1'b0);
    do_txn(KNormal, 4'b1010, 4'b0011, 1'b0);
    do_txn(KLink,   4'b1111, 4'b1100, 1'b0);

    // Reset while the payload confirm is on the bus.
    wait_idle();
    pass_in = PW; data_in = 4'h9; start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    repeat (4) @(posedge clk);
    #1 check("confirm_before_rst", int'(lk.confirm), 1);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    check_zero("rst_mid");
    do_txn(KNormal, 4'b1111, 4'b0110, 1'b1);

`ifdef LOCK_REQ_TIMEOUT_EN
    wait_idle();
    ctrl_stuck = 1'b1;
    issue_start(KTime, PW, 4'h7);
    repeat (TO - 1) @(posedge clk);
    #1 check("rqst_before_timeout", int'(lk.rqst), 1);
    @(posedge clk);
    #1 check("rqst_after_timeout", int'(lk.rqst), 0);
    drain(10);
    ctrl_stuck = 1'b0;
`endif

    for (int i = 0; i < 30; i++) begin
      int         kind;
      logic [3:0] p;
      kind = ($urandom_range(0, 3) == 0) ? KLink : KNormal;
      p    = (kind == KLink || $urandom_range(0, 1) == 1) ? PW : 4'($urandom);
      do_txn(kind, p, 4'($urandom), 1'($urandom_range(0, 1)));
    end

    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
